// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the data-memory arbiter.
// slave  : arbiter view (takes requests, drives acks/rdata and the memory bus).
// master : environment view (requesters plus the memory model).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // requester 0: CPU load/store port
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_ack;
    // requester 1: loader/debug port
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_ack;
    // data memory (combinational read, posedge write)
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_rdata, r0_ack,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_rdata, r1_ack,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_rdata, r0_ack,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_rdata, r1_ack,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin sequencer for the 256-byte data memory.
// Each transaction is IDLE (grant) -> ACCESS (one memory cycle) -> DONE (ack).
// Optional grant counters are compiled in when MEMARB_GNT_CNT_EN is defined;
// otherwise gnt_cnt0/gnt_cnt1 are tied to zero.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic [15:0]      gnt_cnt0,
    output logic [15:0]      gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state;
    logic                     prio;       // requester that wins a tie
    logic                     gnt_id;     // requester owning the current transaction
    logic                     gnt_we;
    logic [1:0]               ack_q;
    logic [1:0][DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic                     rd_q;
    logic                     wr_q;

    logic [1:0]               req;
    logic                     grant;
    logic                     pick;
    logic                     sel_we;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;

    assign req = {bus.r1_req, bus.r0_req};

    // Winner selection: a lone request wins, a tie goes to the priority holder.
    always_comb begin
        grant     = |req;
        pick      = (req == 2'b11) ? prio : req[1];
        sel_we    = pick ? bus.r1_we    : bus.r0_we;
        sel_addr  = pick ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = pick ? bus.r1_wdata : bus.r0_wdata;
    end

    // Transaction FSM; every output is a register, request fields are captured at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'(RR_INIT);
            gnt_id  <= 1'b0;
            gnt_we  <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gnt_id  <= pick;
                        gnt_we  <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        rd_q    <= !sel_we;
                        wr_q    <= sel_we;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // memory commits a write / presents read data at this edge
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    if (!gnt_we) rdata_q[gnt_id] <= bus.mem_rdata;
                    ack_q[gnt_id] <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    ack_q <= '0;
                    prio  <= ~gnt_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_read  = rd_q;
    assign bus.mem_write = wr_q;
    assign bus.r0_ack    = ack_q[0];
    assign bus.r1_ack    = ack_q[1];
    assign bus.r0_rdata  = rdata_q[0];
    assign bus.r1_rdata  = rdata_q[1];

`ifdef MEMARB_GNT_CNT_EN
    logic [1:0][15:0] cnt_q;

    // Saturating per-requester grant counters, bumped on each IDLE->ACCESS grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state == IDLE && grant && cnt_q[pick] != 16'hFFFF) begin
            cnt_q[pick] <= cnt_q[pick] + 16'd1;
        end
    end

    assign gnt_cnt0 = cnt_q[0];
    assign gnt_cnt1 = cnt_q[1];
`else
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif

endmodule
